pulse_train_gen: RTL and testbench
==================================

Name: pulse_train_gen

Overview:
- Generates a burst of single-cycle increment pulses for a downstream counter's incr input.
- One start request loads a pulse count and an inter-pulse gap.
- The block emits exactly that many pulses, then signals done.
- Serves as the stimulus-producing end of the counter's incr interface; used in benches and as a programmable tick source in the design.

Parameters:
- N_WIDTH, 4: width of the pulse count and of the remaining output; matches the driven counter's width.
- GAP_WIDTH, 4: width of the gap field; gap = number of idle cycles between consecutive pulses.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- count  input  N_WIDTH  number of pulses to emit; latched when start is accepted.
- gap  input  GAP_WIDTH  idle cycles between pulses; latched when start is accepted.
- pulse  output  1  one-cycle increment pulse, connects to the counter's incr.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion strobe.
- remaining  output  N_WIDTH  pulses still to emit in the current burst.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port named reset.
- Reset (asynchronous, any time, including mid-burst):
  - state=IDLE; pulse=0, busy=0, done=0, remaining=0.
  - Latched count and gap cleared; internal gap counter cleared.
  - No pulse is emitted in the cycle after reset deasserts.
- States: IDLE, PULSE, GAP, DONE. Outputs are decoded from registered state only (Moore), with no combinational path from inputs to outputs.
  - pulse = (state==PULSE).
  - busy = (state!=IDLE).
  - done = (state==DONE).
- IDLE:
  - start=1 and count!=0: latch count into remaining, latch gap, go to PULSE.
  - start=1 and count==0: go to DONE directly; no pulse is emitted.
  - start=0: stay in IDLE.
- PULSE (one cycle): remaining decrements by 1 at the end of the cycle.
  - Decremented value == 0: go to DONE.
  - Else, latched gap == 0: stay in PULSE (back-to-back pulses).
  - Else: load the gap counter with gap-1 and go to GAP.
- GAP: gap counter decrements each cycle; when it reads 0, go to PULSE. The block therefore spends exactly gap cycles in GAP.
- DONE: lasts exactly one cycle, then IDLE. remaining=0 during DONE.
- Latency:
  - start sampled high at edge k gives the first pulse high in cycle k..k+1.
  - Pulse period = gap+1 cycles.
  - done is high in the cycle immediately after the last pulse cycle.
- start while busy (PULSE, GAP or DONE) is ignored. The count and gap inputs may change freely after acceptance.
- A new start may be accepted in the first IDLE cycle after DONE. Minimum turnaround is DONE + 1 cycle.
- count = 2^N_WIDTH-1 and gap = 2^GAP_WIDTH-1 must work with no overflow. All arithmetic is unsigned and wraps nowhere, because decrements stop at 0.

Test Plan:
- count=5, gap=0, start pulsed 1 cycle: pulse high for 5 consecutive cycles starting 1 cycle after start; remaining 5,4,3,2,1 during them; done high in cycle 6; busy high for 6 cycles.
- count=3, gap=2: pulse high at relative cycles 1, 4, 7, low otherwise; done at cycle 8; total 3 pulses.
- count=0, start: no pulse; done high the next cycle; busy high that single cycle only.
- Start again during GAP with count=9: ignored, current burst finishes with the original pulse total and done timing; a start issued after done is accepted normally.
- Reset asserted asynchronously mid-GAP of a count=7 burst: all outputs 0 immediately; after release, no pulses until a new start arrives.
- Drive a 4-bit up-counter's incr from pulse, with count=15, gap=1 after counter reset: the counter output y reads 15 when done asserts, and stays 15 afterwards.

Source files
------------

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: emits a programmable burst of single-cycle increment pulses
// separated by a fixed number of idle cycles, then a one-cycle done strobe.
// All outputs are decoded from registered state only.
module pulse_train_gen #(
  parameter int N_WIDTH   = 4,
  parameter int GAP_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N_WIDTH-1:0]   count,
  input  logic [GAP_WIDTH-1:0] gap,
  output logic                 pulse,
  output logic                 busy,
  output logic                 done,
  output logic [N_WIDTH-1:0]   remaining
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q,     state_d;
  logic [N_WIDTH-1:0]   remaining_q, remaining_d;
  logic [GAP_WIDTH-1:0] gap_lat_q,   gap_lat_d;
  logic [GAP_WIDTH-1:0] gap_cnt_q,   gap_cnt_d;

  // State and datapath registers; reset clears everything so no stale burst resumes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      gap_lat_q   <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      gap_lat_q   <= gap_lat_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  // Next-state logic; decrements are guarded so no counter ever wraps below zero.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    gap_lat_d   = gap_lat_q;
    gap_cnt_d   = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count != '0) begin
            remaining_d = count;
            gap_lat_d   = gap;
            state_d     = S_PULSE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_PULSE: begin
        remaining_d = remaining_q - N_WIDTH'(1);
        if (remaining_q == N_WIDTH'(1)) begin
          state_d = S_DONE;
        end else if (gap_lat_q == '0) begin
          state_d = S_PULSE;
        end else begin
          // Loaded with gap-1 so that GAP lasts exactly gap cycles.
          gap_cnt_d = gap_lat_q - GAP_WIDTH'(1);
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = S_PULSE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pulse     = (state_q == S_PULSE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign remaining = remaining_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: expected per-cycle outputs are generated
// from count/gap, queued when a start is driven, and popped each cycle.
module tb_pulse_train_gen;

  typedef struct packed {
    logic       p;
    logic       b;
    logic       d;
    logic [3:0] r;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] count = '0;
  logic [3:0] gap = '0;
  logic       pulse, busy, done;
  logic [3:0] remaining;

  logic       ctr_rst = 1'b1;
  logic [3:0] y_q;

  int   errors = 0;
  int   checks = 0;
  obs_t exp_q[$];

  pulse_train_gen #(.N_WIDTH(4), .GAP_WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .count     (count),
    .gap       (gap),
    .pulse     (pulse),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  // Downstream 4-bit up-counter driven by pulse.
  always_ff @(posedge clk) begin
    if (ctr_rst) y_q <= '0;
    else if (pulse) y_q <= y_q + 4'd1;
  end

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Expected timeline: pulses at t = i*(gap+1), remaining drops after each pulse.
  task automatic push_burst(input int c, input int g);
    obs_t e;
    int   total;
    int   k;
    if (c != 0) begin
      total = (c - 1) * (g + 1) + 1;
      for (int t = 0; t < total; t++) begin
        k = t / (g + 1);
        e.p = ((t % (g + 1)) == 0);
        e.b = 1'b1;
        e.d = 1'b0;
        e.r = e.p ? 4'(c - k) : 4'(c - k - 1);
        exp_q.push_back(e);
      end
    end
    e = '{p: 1'b0, b: 1'b1, d: 1'b1, r: 4'd0};
    exp_q.push_back(e);
    e = '{p: 1'b0, b: 1'b0, d: 1'b0, r: 4'd0};
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag, input int inj, input bit chk_y);
    obs_t e;
    int   i;
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      chk($sformatf("%s_c%0d", tag, i + 1), {pulse, busy, done, remaining}, e);
      if (chk_y && e.d) chk({tag, "_y_at_done"}, {3'b000, y_q}, 7'd15);
      if (i == inj) begin
        start = 1'b1;
        count = 4'd9;
        gap   = 4'd0;
      end
      i++;
    end
  endtask

  // Called at a negedge in IDLE: start is sampled by the next rising edge.
  task automatic burst(input int c, input int g, input string tag, input int inj, input bit chk_y);
    start = 1'b1;
    count = 4'(c);
    gap   = 4'(g);
    push_burst(c, g);
    drain(tag, inj, chk_y);
  endtask

  initial begin
    @(negedge clk);
    chk("reset_state", {pulse, busy, done, remaining}, 7'd0);
    reset = 1'b0;
    ctr_rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("idle_after_reset", {pulse, busy, done, remaining}, 7'd0);
    end

    burst(5, 0, "c5g0", -1, 1'b0);
    burst(3, 2, "c3g2", -1, 1'b0);
    burst(0, 0, "c0", -1, 1'b0);
    burst(3, 2, "ign_start", 1, 1'b0);
    burst(2, 1, "after_done", -1, 1'b0);

    // Asynchronous reset in the middle of a gap.
    start = 1'b1; count = 4'd7; gap = 4'd3;
    @(negedge clk);
    start = 1'b0;
    chk("rst_burst_pulse", {pulse, busy, done, remaining}, {3'b110, 4'd7});
    @(negedge clk);
    chk("rst_burst_gap", {pulse, busy, done, remaining}, {3'b010, 4'd6});
    #2 reset = 1'b1;
    #1 chk("async_rst", {pulse, busy, done, remaining}, 7'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_idle", {pulse, busy, done, remaining}, 7'd0);
    end
    burst(4, 1, "post_rst_burst", -1, 1'b0);

    // Counter driven by pulse: 15 pulses with gap 1.
    ctr_rst = 1'b1;
    @(negedge clk);
    ctr_rst = 1'b0;
    chk("ctr_cleared", {3'b000, y_q}, 7'd0);
    burst(15, 1, "ctr", -1, 1'b1);
    repeat (3) @(negedge clk);
    chk("ctr_hold", {3'b000, y_q}, 7'd15);

    burst(15, 15, "max", -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
